alu_acc_ctrl: RTL and testbench

ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_acc_datapath.sv | 27 ++
 rtl/alu_acc_ctrl.sv | 86 ++++++++
 tb/tb_alu_acc_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state encodings for the accumulator ALU
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_LOAD = 3'd4,
    OP_CLR  = 3'd5
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_acc_datapath.sv
// alu_acc_datapath: combinational evaluation of one accumulator operation
module alu_acc_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   result_o,
  output logic             illegal_o
);
  // unsigned (WIDTH+1)-bit result; bit WIDTH is carry for ADD, borrow for SUB
  always_comb begin
    result_o  = {1'b0, a_i};
    illegal_o = 1'b0;
    case (op_e'(op_i))
      OP_ADD:  result_o = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  result_o = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  result_o = {1'b0, a_i & b_i};
      OP_OR:   result_o = {1'b0, a_i | b_i};
      OP_LOAD: result_o = {1'b0, b_i};
      OP_CLR:  result_o = '0;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: handshaked accumulator ALU with IDLE/EXEC/RESP sequencing
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_operand_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cmd_cnt_o
);
  state_e           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_b, r_acc;
  logic             r_carry, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_result;
  logic             w_illegal, w_accept;

  assign w_accept    = cmd_valid_i && r_state == ST_IDLE;
  assign cmd_ready_o = r_state == ST_IDLE;
  assign rsp_valid_o = r_state == ST_RESP;
  assign acc_o       = r_acc;
  assign carry_o     = r_carry;
  assign zero_o      = r_acc == '0;
  assign err_o       = r_err;
  assign cmd_cnt_o   = r_cnt;

  alu_acc_datapath #(.WIDTH(WIDTH)) u_dp (
    .op_i      (r_op),
    .a_i       (r_acc),
    .b_i       (r_b),
    .result_o  (w_result),
    .illegal_o (w_illegal)
  );

  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;

  // next state: accept in IDLE, one EXEC cycle, hold RESP until consumed
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = cmd_valid_i ? ST_EXEC : ST_IDLE;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: w_next = rsp_ready_i ? ST_IDLE : ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end

  // latch command on acceptance, commit result in EXEC; illegal ops keep acc/carry
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_op    <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op_i;
        r_b   <= cmd_operand_i;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == ST_EXEC) begin
        r_err <= w_illegal;
        if (!w_illegal) begin
          r_acc   <= w_result[WIDTH-1:0];
          r_carry <= w_result[WIDTH];
        end
      end
    end
endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: vector table, corner sequences and randomized model check
module tb_alu_acc_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_operand = '0;
  logic       cmd_ready_o, rsp_valid_o, carry_o, zero_o, err_o;
  logic [7:0] acc_o, cmd_cnt_o;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_acc = -1, last_hold = 0;
  int m_acc = 0, m_carry = 0, m_err = 0, m_cnt = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] acc;
    logic       carry;
    logic       err;
  } vec_t;
  vec_t vecs [15];

  alu_acc_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op),
    .cmd_operand_i(cmd_operand),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .acc_o        (acc_o),
    .carry_o      (carry_o),
    .zero_o       (zero_o),
    .err_o        (err_o),
    .cmd_cnt_o    (cmd_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input int op, input int b);
    int s;
    case (op)
      0: begin s = m_acc + b; m_acc = s % 256; m_carry = (s > 255) ? 1 : 0; m_err = 0; end
      1: begin m_carry = (m_acc < b) ? 1 : 0; m_acc = (m_acc - b + 256) % 256; m_err = 0; end
      2: begin m_acc = m_acc & b; m_carry = 0; m_err = 0; end
      3: begin m_acc = m_acc | b; m_carry = 0; m_err = 0; end
      4: begin m_acc = b; m_carry = 0; m_err = 0; end
      5: begin m_acc = 0; m_carry = 0; m_err = 0; end
      default: m_err = 1;
    endcase
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_acc"}, acc_o, m_acc);
    chk({tag, "_carry"}, carry_o, m_carry);
    chk({tag, "_zero"}, zero_o, (m_acc == 0) ? 1 : 0);
    chk({tag, "_err"}, err_o, m_err);
    chk({tag, "_cnt"}, cmd_cnt_o, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_acc = 0; m_carry = 0; m_err = 0; m_cnt = 0; last_acc = -1;
    chk_state("rst");
    chk("rst_rsp_valid", rsp_valid_o, 0);
    rst = 1'b0;
  endtask

  // called at a negedge with the block in IDLE; returns at a negedge in IDLE
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] b, input int hold);
    int edges;
    logic [7:0] sa;
    logic sc, se;
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = b;
    chk("cmd_ready", cmd_ready_o, 1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    if (last_acc >= 0) chk("period", cyc - last_acc, 3 + last_hold);
    last_acc = cyc; last_hold = hold;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_operand = 8'($urandom);
    rsp_ready = 1'($urandom_range(0, 1));
    while (!rsp_valid_o && edges < 8) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency", edges, 2);
    model(int'(op), int'(b));
    chk_state("rsp");
    sa = acc_o; sc = carry_o; se = err_o;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_operand = 8'h99;
      @(posedge clk);
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid_o, 1);
      chk("hold_cmd_ready", cmd_ready_o, 0);
      chk("hold_acc", acc_o, sa);
      chk("hold_carry", carry_o, sc);
      chk("hold_err", err_o, se);
      chk("hold_cnt", cmd_cnt_o, m_cnt);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid_o, 0);
  endtask

  initial begin
    vecs[0]  = '{3'd4, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[2]  = '{3'd4, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[3]  = '{3'd1, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[4]  = '{3'd1, 8'hFE, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 8'hCC, 8'hCC, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 8'h11, 8'hCC, 1'b0, 1'b1};
    vecs[7]  = '{3'd3, 8'h03, 8'hCF, 1'b0, 1'b0};
    vecs[8]  = '{3'd2, 8'h0F, 8'h0F, 1'b0, 1'b0};
    vecs[9]  = '{3'd7, 8'h00, 8'h0F, 1'b0, 1'b1};
    vecs[10] = '{3'd5, 8'h55, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[12] = '{3'd0, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{3'd6, 8'h3C, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{3'd1, 8'h01, 8'hFF, 1'b1, 1'b0};

    do_reset();
    foreach (vecs[k]) begin
      run_cmd(vecs[k].op, vecs[k].b, 0);
      chk("vec_acc", acc_o, vecs[k].acc);
      chk("vec_carry", carry_o, vecs[k].carry);
      chk("vec_zero", zero_o, (vecs[k].acc == 8'h00) ? 1 : 0);
      chk("vec_err", err_o, vecs[k].err);
    end

    run_cmd(3'd4, 8'h3A, 0);
    run_cmd(3'd0, 8'h01, 5);
    run_cmd(3'd3, 8'h80, 0);

    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_operand = 8'h77;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_rsp_valid", rsp_valid_o, 0);
    rst = 1'b1;
    #1;
    chk("exec_rst_acc", acc_o, 0);
    chk("exec_rst_cnt", cmd_cnt_o, 0);
    chk("exec_rst_zero", zero_o, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      chk("exec_rst_no_rsp", rsp_valid_o, 0);
    end
    chk("exec_rst_ready", cmd_ready_o, 1);
    m_acc = 0; m_carry = 0; m_err = 0; m_cnt = 0; last_acc = -1;

    for (int i = 0; i < 200; i++)
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2));

    do_reset();
    for (int i = 0; i < 256; i++)
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 0);
    chk("wrap_cnt", cmd_cnt_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
